// File: rtl/lsu_bus_ctrl_if.sv
// rtl/lsu_bus_ctrl_if.sv - word-bus request/response channel between the LSU and memory
interface lsu_bus_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  bus_req_valid;
    logic                  bus_req_ready;
    logic [ADDR_W-1:0]     bus_addr;
    logic                  bus_we;
    logic [DATA_W-1:0]     bus_wdata;
    logic [DATA_W/8-1:0]   bus_wstrb;
    logic                  bus_resp_valid;
    logic                  bus_resp_ready;
    logic [DATA_W-1:0]     bus_rdata;

    modport master (
        output bus_req_valid, bus_addr, bus_we, bus_wdata, bus_wstrb, bus_resp_ready,
        input  bus_req_ready, bus_resp_valid, bus_rdata
    );

    modport slave (
        input  bus_req_valid, bus_addr, bus_we, bus_wdata, bus_wstrb, bus_resp_ready,
        output bus_req_ready, bus_resp_valid, bus_rdata
    );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// rtl/lsu_bus_ctrl.sv - load/store unit turning core memory requests into aligned word-bus transactions
module lsu_bus_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_w,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    output logic [DATA_W-1:0] mem_r,
    output logic              done,
    output logic              err,
    output logic              busy,
    lsu_bus_ctrl_if.master    bus
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [OFF_W-1:0]  off_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [NB-1:0]     wstrb_q;

    logic              req_any;
    logic              chk_err;
    logic [NB-1:0]     mask;
    logic [NB-1:0]     strb_c;
    logic [DATA_W-1:0] wdata_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] load_val;
    logic              tmo_hit;
    logic              latch;
    logic              set_tmo;
    logic              capture;

    assign req_any = mem_r_en | mem_w_en;

    // Requests the bus cannot express are rejected before any bus activity.
    assign chk_err = (mem_r_en & mem_w_en)
                   | (mem_size == 2'd3)
                   | ((mem_size == 2'd1) & mem_addr[0])
                   | ((mem_size == 2'd2) & (|mem_addr[OFF_W-1:0]));

    always_comb begin
        mask = '1;
        case (mem_size)
            2'd0:    mask = NB'(1);
            2'd1:    mask = NB'(3);
            default: mask = '1;
        endcase
    end

    assign strb_c = mem_w_en ? (mask << mem_addr[OFF_W-1:0]) : '0;
    assign addr_c = {mem_addr[ADDR_W-1:OFF_W], OFF_W'(0)};

    always_comb begin
        wdata_c = mem_w;
        case (mem_size)
            2'd0:    wdata_c = {NB{mem_w[7:0]}};
            2'd1:    wdata_c = {(DATA_W/16){mem_w[15:0]}};
            default: wdata_c = mem_w;
        endcase
    end

    assign shifted = bus.bus_rdata >> {off_q, 3'b000};

    always_comb begin
        load_val = shifted;
        case (size_q)
            2'd0:    load_val = {{(DATA_W-8){~uns_q & shifted[7]}}, shifted[7:0]};
            2'd1:    load_val = {{(DATA_W-16){~uns_q & shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    // cnt_inc can exceed TIMEOUT by one when the request handshake lands on the last cycle.
    assign cnt_inc = cnt + 1'b1;
    assign tmo_hit = (cnt_inc >= CNT_W'(TIMEOUT));

    always_comb begin
        state_n = state;
        latch   = 1'b0;
        set_tmo = 1'b0;
        capture = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_any) begin
                    latch   = 1'b1;
                    state_n = chk_err ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (bus.bus_req_ready) begin
                    state_n = S_WAIT;
                end else if (tmo_hit) begin
                    set_tmo = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_WAIT: begin
                if (bus.bus_resp_valid) begin
                    capture = ~we_q;
                    state_n = S_DONE;
                end else if (tmo_hit) begin
                    set_tmo = 1'b1;
                    state_n = S_DONE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            size_q  <= '0;
            uns_q   <= 1'b0;
            off_q   <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            mem_r   <= '0;
        end else begin
            state <= state_n;
            if (latch) begin
                size_q  <= mem_size;
                uns_q   <= mem_unsigned;
                off_q   <= mem_addr[OFF_W-1:0];
                err_q   <= chk_err;
                cnt     <= '0;
                addr_q  <= addr_c;
                we_q    <= mem_w_en;
                wdata_q <= wdata_c;
                wstrb_q <= strb_c;
            end
            if (state == S_REQ || state == S_WAIT) begin
                cnt <= cnt_inc;
            end
            if (set_tmo) begin
                err_q <= 1'b1;
            end
            if (capture) begin
                mem_r <= load_val;
            end
        end
    end

    assign bus.bus_req_valid  = (state == S_REQ);
    assign bus.bus_resp_ready = (state == S_WAIT);
    assign bus.bus_addr       = addr_q;
    assign bus.bus_we         = we_q;
    assign bus.bus_wdata      = wdata_q;
    assign bus.bus_wstrb      = wstrb_q;

    assign done = (state == S_DONE);
    assign err  = (state == S_DONE) & err_q;
    assign busy = (state != S_IDLE);
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb/tb_lsu_bus_ctrl.sv - scoreboard bench for lsu_bus_ctrl with a byte-lane reference model
module tb_lsu_bus_ctrl;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en, mem_w_en, mem_unsigned;
    logic [31:0] mem_addr, mem_w, mem_r;
    logic [1:0]  mem_size;
    logic        done, err, busy;

    lsu_bus_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus();

    lsu_bus_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_w(mem_w),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_r(mem_r),
        .done(done), .err(err), .busy(busy), .bus(bus)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit          err;
        logic [31:0] mem_r;
        logic [31:0] addr;
        bit          we;
        logic [3:0]  strb;
        logic [31:0] wdata;
        int          lat;
        int          reqc;
        longint      start;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem_r = '0;
    int          total = 0;
    int          bad = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, pops one expectation per done pulse.
    int   reqc_seen = 0;
    exp_t m;
    always @(negedge clk) begin
        if (rst) begin
            reqc_seen = 0;
        end else begin
            if (bus.bus_req_valid) begin
                reqc_seen++;
                if (bus.bus_req_ready && exp_q.size() > 0) begin
                    check("bus_addr", bus.bus_addr, exp_q[0].addr);
                    check("bus_we", bus.bus_we, exp_q[0].we);
                    check("bus_wstrb", bus.bus_wstrb, exp_q[0].strb);
                    if (exp_q[0].we) check("bus_wdata", bus.bus_wdata, exp_q[0].wdata);
                end
            end
            if (done) begin
                check("pending_at_done", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    m = exp_q.pop_front();
                    check("err", err, m.err);
                    check("mem_r", mem_r, m.mem_r);
                    check("latency", cyc - m.start, m.lat);
                    check("req_valid_cycles", reqc_seen, m.reqc);
                end
                reqc_seen = 0;
            end
        end
    end

    // Reference: rules applied per byte lane; rq/rs < 0 means the bus never answers.
    task automatic do_op(bit r, bit w, logic [31:0] a, logic [31:0] d, logic [1:0] sz, bit u,
                         logic [31:0] rd, int rq, int rs);
        exp_t        e;
        int          nb, off, rc, wc;
        bit          legal, got;
        logic [63:0] v;
        nb  = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        off = a % 4;
        legal = !(r && w) && sz != 3 && !(sz == 1 && off % 2 != 0) && !(sz == 2 && off != 0);
        e.addr = a & ~32'd3;
        e.we   = w;
        for (int i = 0; i < 4; i++) begin
            e.strb[i]       = w && i >= off && i < off + nb;
            e.wdata[8*i+:8] = d[8*(i % nb)+:8];
        end
        e.err = 1'b1;
        if (!legal) begin
            e.lat = 1; e.reqc = 0;
        end else if (rq < 0) begin
            e.lat = 1 + TO; e.reqc = TO;
        end else if (rs < 0) begin
            e.lat = 1 + TO; e.reqc = rq + 1;
        end else begin
            e.err = 1'b0; e.lat = 3 + rq + rs; e.reqc = rq + 1;
            if (r) begin
                v = '0;
                for (int j = 0; j < nb; j++) v[8*j+:8] = rd[8*(off+j)+:8];
                if (!u && v[8*nb-1]) v = v | (~64'd0 << (8*nb));
                model_mem_r = v[31:0];
            end
        end
        e.mem_r = model_mem_r;

        mem_r_en = r; mem_w_en = w; mem_addr = a; mem_w = d; mem_size = sz; mem_unsigned = u;
        e.start = cyc;
        exp_q.push_back(e);
        rc = 0; wc = 0; got = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(posedge clk); #1;
            if (done) begin
                got = 1;
            end else begin
                bus.bus_req_ready = bus.bus_req_valid && rq >= 0 && rc >= rq;
                if (bus.bus_req_valid) rc++;
                bus.bus_resp_valid = 1'b0;
                if (bus.bus_resp_ready) begin
                    bus.bus_resp_valid = rs >= 0 && wc >= rs;
                    bus.bus_rdata      = rd;
                    wc++;
                end
            end
        end
        check("op_completed", got, 1);
        if (!got) exp_q.delete();
        mem_r_en = 0; mem_w_en = 0;
        bus.bus_req_ready = 0;
        bus.bus_resp_valid = (rs < 0);
        @(posedge clk); #1;
        bus.bus_resp_valid = 0;
    endtask

    task automatic check_reset_outputs();
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_r", mem_r, 0);
        check("rst_bus_addr", bus.bus_addr, 0);
        check("rst_bus_wdata", bus.bus_wdata, 0);
        check("rst_bus_wstrb", bus.bus_wstrb, 0);
        check("rst_bus_we", bus.bus_we, 0);
        check("rst_req_valid", bus.bus_req_valid, 0);
        check("rst_resp_ready", bus.bus_resp_ready, 0);
    endtask

    initial begin
        bit          rr, ww, seen;
        int          k, rq, rs, nb;
        logic [1:0]  sz;
        logic [31:0] a;
        rst = 1; mem_r_en = 0; mem_w_en = 0; mem_addr = 0; mem_w = 0; mem_size = 0; mem_unsigned = 0;
        bus.bus_req_ready = 0; bus.bus_resp_valid = 0; bus.bus_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 0;
        @(posedge clk); #1;

        do_op(1, 0, 32'h8000_0010, 32'h0, 2, 0, 32'hDEAD_BEEF, 0, 0);
        do_op(1, 0, 32'h8000_0003, 32'h0, 0, 1, 32'hAB12_3456, 0, 0);
        do_op(1, 0, 32'h8000_0003, 32'h0, 0, 0, 32'hAB12_3456, 1, 2);
        do_op(0, 1, 32'h8000_0002, 32'h1234_BEEF, 1, 0, 32'h5555_5555, 0, 0);
        do_op(0, 1, 32'h8000_0001, 32'hCAFE_F00D, 0, 0, 32'h0, 2, 1);
        do_op(1, 0, 32'h8000_0002, 32'h0, 2, 0, 32'h1111_2222, 0, 0);
        do_op(1, 0, 32'h8000_0001, 32'h0, 1, 1, 32'h1111_2222, 0, 0);
        do_op(1, 0, 32'h8000_0000, 32'h0, 3, 0, 32'h1111_2222, 0, 0);
        do_op(1, 1, 32'h8000_0000, 32'h0, 2, 0, 32'h1111_2222, 0, 0);
        do_op(1, 0, 32'h8000_0040, 32'h0, 2, 0, 32'h7777_8888, -1, 0);
        do_op(0, 1, 32'h8000_0044, 32'h1, 2, 0, 32'h0, 0, -1);
        do_op(1, 0, 32'h8000_0006, 32'h0, 1, 0, 32'h8001_0000, 0, 0);

        // Abort a load in WAIT with reset, then offer a stale response.
        mem_r_en = 1; mem_addr = 32'h8000_0020; mem_size = 2; mem_unsigned = 0;
        seen = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(posedge clk); #1;
            bus.bus_req_ready = bus.bus_req_valid;
            seen = bus.bus_resp_ready;
        end
        check("reached_wait", seen, 1);
        rst = 1; mem_r_en = 0; bus.bus_req_ready = 0;
        @(posedge clk); #1;
        rst = 0; bus.bus_resp_valid = 1; bus.bus_rdata = 32'h1111_1111;
        @(posedge clk); #1;
        bus.bus_resp_valid = 0;
        check_reset_outputs();
        model_mem_r = '0;
        do_op(1, 0, 32'h8000_0010, 32'h0, 2, 0, 32'h0BAD_F00D, 0, 0);

        for (int i = 0; i < 200; i++) begin
            k  = $urandom_range(0, 19);
            rr = (k == 0) || (k < 10);
            ww = (k == 0) || (k >= 10);
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(nb) - 32'd1);
            rq = $urandom_range(0, 2);
            rs = $urandom_range(0, 2);
            k  = $urandom_range(0, 29);
            if (k == 0) rq = -1;
            if (k == 1) rs = -1;
            do_op(rr, ww, a, $urandom, sz, 1'($urandom_range(0, 1)), $urandom, rq, rs);
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
